// File: rtl/fb_port_arbiter_pkg.sv
// rtl/fb_port_arbiter_pkg.sv - shared frame-buffer constants and grant encodings
package fb_port_arbiter_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_HOLD  = 2'd2,
        GNT_WRITE = 2'd3
    } grant_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - VGA read, capture write and frame-buffer RAM bus
interface fb_port_arbiter_if #(
    parameter int ADDR_W = fb_port_arbiter_pkg::FB_ADDR_W,
    parameter int DATA_W = fb_port_arbiter_pkg::FB_DATA_W
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        output rd_data, rd_valid, wr_ready, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        input  rd_data, rd_valid, wr_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/fb_port_arbiter_wr_fifo.sv
// rtl/fb_port_arbiter_wr_fifo.sv - synchronous {addr,data} write FIFO (module fb_wr_fifo)
module fb_wr_fifo #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [ADDR_W-1:0]       push_addr,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [ADDR_W-1:0]       head_addr,
    output logic [DATA_W-1:0]       head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [PW:0]              r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= {push_addr, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign {head_addr, head_data} = r_mem[r_rd_ptr];
    assign full  = (r_count == C_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer port arbiter, VGA read priority; FB_ARB_STATS_EN adds stats
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK25,
    input  logic                          rst_n,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]                   stat_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   stat_hiwater,
`endif
    fb_port_arbiter_if.slave              bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    grant_t            w_gnt;
    logic              w_hit;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_last_valid;
    logic              r_v1, r_v2, r_sel1, r_sel2;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    assign w_hit = r_last_valid && (bus.rd_addr == r_last_addr);

    always_comb begin
        w_gnt = GNT_IDLE;
        if (bus.rd_req)   w_gnt = w_hit ? GNT_HOLD : GNT_READ;
        else if (!w_empty) w_gnt = GNT_WRITE;
    end

    // A HOLD slot frees the RAM, so a queued write may use it; a pop makes room for a push even when full.
    assign w_pop  = (w_gnt == GNT_WRITE) || ((w_gnt == GNT_HOLD) && !w_empty);
    assign w_push = bus.wr_req && (!w_full || w_pop);

    fb_wr_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLK25),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_addr (bus.wr_addr),
        .push_data (bus.wr_data),
        .pop       (w_pop),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge CLK25) begin
        if (!rst_n) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_last_addr  <= '0;
            r_last_valid <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_sel1       <= 1'b0;
            r_sel2       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_mem_we <= w_pop;
            if (w_gnt == GNT_READ) begin
                r_mem_addr  <= bus.rd_addr;
                r_last_addr <= bus.rd_addr;
            end else if (w_pop) begin
                r_mem_addr  <= w_head_addr;
                r_mem_wdata <= w_head_data;
            end
            r_last_valid <= bus.rd_req;
            // Both slot types travel the same 2-stage pipe so output alignment is fixed.
            r_v1       <= bus.rd_req;
            r_sel1     <= (w_gnt == GNT_READ);
            r_v2       <= r_v1;
            r_sel2     <= r_sel1;
            r_rd_valid <= r_v2;
            if (r_v2 && r_sel2) r_rd_data <= bus.mem_rdata;
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge CLK25) begin
        if (!rst_n) begin
            stat_drop_cnt <= '0;
            stat_hiwater  <= '0;
        end else begin
            if (bus.wr_req && !bus.wr_ready && (stat_drop_cnt != 16'hFFFF))
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            if (w_count > stat_hiwater) stat_hiwater <= w_count;
        end
    end
`endif

    assign bus.wr_ready  = (w_count != C_FULL);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;

endmodule
